ssd_arbiter: RTL and testbench

SSD_ARBITER -- requirements
Module: ssd_arbiter

---
 rtl/ssd_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ssd_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_arbiter.sv
// ssd_arbiter: round-robin arbiter that hands the four-digit seven-segment
// display to one of NUM_REQ requesters, holding each owner for at least
// MIN_HOLD cycles before the display may change hands.
// Optional build macro: SSD_ARB_PREEMPT_EN lets requester 0 take the display
// from any other owner immediately.
module ssd_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MIN_HOLD = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [16*NUM_REQ-1:0] req_digits,
  input  logic [4*NUM_REQ-1:0]  req_en,
  output logic [NUM_REQ-1:0]    grant,
  output logic [15:0]           ssd_digits,
  output logic [3:0]            ssd_enable,
  output logic                  busy,
  output logic                  switch_pulse
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] HOLD_LOAD = 16'(MIN_HOLD - 1);

  typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;

  state_t               state, state_nxt;
  logic [15:0]          cnt, cnt_nxt;
  logic [IW-1:0]        owner, owner_nxt;
  logic [IW-1:0]        last_owner, last_nxt;
  logic [NUM_REQ-1:0]   grant_nxt;
  logic [15:0]          digits_nxt;
  logic [3:0]           enable_nxt;
  logic                 pulse_nxt;
  logic                 take;
  logic [IW-1:0]        new_idx;
  logic                 owner_req;
  logic [NUM_REQ-1:0]   others;
  logic [15:0]          dig_arr [NUM_REQ];
  logic [3:0]           en_arr  [NUM_REQ];

  // First requester set in mask, searching upward from base+1 with wrap.
  function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] base,
                                            input logic [NUM_REQ-1:0] mask);
    logic [IW-1:0] pick;
    logic          found;
    int unsigned   b;
    int unsigned   idx;
    pick  = base;
    found = 1'b0;
    b     = 32'(base);
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (b + i) % 32'(NUM_REQ);
      if (!found && mask[IW'(idx)]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Split the flat digit/enable buses into per-requester slots.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      dig_arr[i] = req_digits[16*i +: 16];
      en_arr[i]  = req_en[4*i +: 4];
    end
  end

  // Next-state, grant selection and display update.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    owner_nxt  = owner;
    last_nxt   = last_owner;
    grant_nxt  = grant;
    digits_nxt = ssd_digits;
    enable_nxt = ssd_enable;
    pulse_nxt  = 1'b0;
    take       = 1'b0;
    new_idx    = owner;
    owner_req  = req[owner];
    others     = req & ~grant;

    case (state)
      IDLE: begin
        enable_nxt = '0;
        if (|req) begin
          take    = 1'b1;
          new_idx = rr_pick(last_owner, req);
        end
      end
      HOLD: begin
        if (owner_req) begin
          digits_nxt = dig_arr[owner];
          enable_nxt = en_arr[owner];
        end
        if (cnt == '0) state_nxt = OPEN;
        else           cnt_nxt   = cnt - 16'd1;
      end
      OPEN: begin
        if (|others) begin
          take    = 1'b1;
          new_idx = rr_pick(owner, others);
        end else if (owner_req) begin
          digits_nxt = dig_arr[owner];
          enable_nxt = en_arr[owner];
        end else begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          enable_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

`ifdef SSD_ARB_PREEMPT_EN
    if ((state == HOLD || state == OPEN) && req[0] && owner != '0) begin
      take    = 1'b1;
      new_idx = '0;
    end
`endif

    // A new grant overrides whatever the state-specific branch decided.
    if (take) begin
      state_nxt  = HOLD;
      cnt_nxt    = HOLD_LOAD;
      owner_nxt  = new_idx;
      last_nxt   = new_idx;
      grant_nxt  = NUM_REQ'(1) << new_idx;
      digits_nxt = dig_arr[new_idx];
      enable_nxt = en_arr[new_idx];
      pulse_nxt  = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      owner        <= '0;
      last_owner   <= IW'(NUM_REQ - 1);
      grant        <= '0;
      ssd_digits   <= '0;
      ssd_enable   <= '0;
      busy         <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      owner        <= owner_nxt;
      last_owner   <= last_nxt;
      grant        <= grant_nxt;
      ssd_digits   <= digits_nxt;
      ssd_enable   <= enable_nxt;
      busy         <= |grant_nxt;
      switch_pulse <= pulse_nxt;
    end
  end

endmodule

// File: tb/tb_ssd_arbiter.sv
// Self-checking bench for ssd_arbiter (NUM_REQ=4, MIN_HOLD=4): a vector table,
// hand-written multi-cycle sequences, and a randomized run against a
// behavioural model that tracks owner and time-since-grant.
module tb_ssd_arbiter;

  localparam int N = 4;
  localparam int M = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [16*N-1:0] req_digits;
  logic [4*N-1:0]  req_en;
  logic [N-1:0]  grant;
  logic [15:0]   ssd_digits;
  logic [3:0]    ssd_enable;
  logic          busy;
  logic          switch_pulse;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  int          m_owner;   // -1 when nobody owns the display
  int          m_age;     // edges since the current grant
  int          m_last;
  logic [15:0] m_dig;
  logic [3:0]  m_en;
  logic        m_pulse;

  ssd_arbiter #(.NUM_REQ(N), .MIN_HOLD(M)) dut (
    .clk(clk), .rst(rst), .req(req), .req_digits(req_digits), .req_en(req_en),
    .grant(grant), .ssd_digits(ssd_digits), .ssd_enable(ssd_enable),
    .busy(busy), .switch_pulse(switch_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  q;
    logic [63:0] d;
    logic [15:0] e;
    logic [3:0]  g;
    logic [15:0] xd;
    logic [3:0]  xe;
    logic        p;
  } vec_t;

  function automatic int next_after(input int base, input logic [3:0] mask);
    int j;
    for (int i = 1; i <= N; i++) begin
      j = (base + i) % N;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    int nw;
    logic [3:0] mask;
    nw = -1;
    m_pulse = 1'b0;
    if (rst) begin
      m_owner = -1; m_age = 0; m_last = N - 1; m_dig = '0; m_en = '0;
    end else begin
      if (m_owner < 0) begin
        if (req != 0) nw = next_after(m_last, req);
      end else begin
`ifdef SSD_ARB_PREEMPT_EN
        if (req[0] && m_owner != 0) nw = 0;
`endif
        if (nw < 0) begin
          if (m_age < M) m_age++;
          else begin
            mask = req;
            mask[m_owner] = 1'b0;
            if (mask != 0) nw = next_after(m_owner, mask);
            else if (!req[m_owner]) begin
              m_owner = -1;
              m_en = '0;
            end
          end
        end
      end
      if (nw >= 0) begin
        m_owner = nw; m_last = nw; m_age = 0; m_pulse = 1'b1;
        m_dig = req_digits[16*nw +: 16];
        m_en  = req_en[4*nw +: 4];
      end else if (m_owner >= 0 && req[m_owner]) begin
        m_dig = req_digits[16*m_owner +: 16];
        m_en  = req_en[4*m_owner +: 4];
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic [3:0] q, input logic [63:0] d, input logic [15:0] e);
    rst = r; req = q; req_digits = d; req_en = e;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic [3:0] g, input logic [15:0] d,
                            input logic [3:0] e, input logic p);
    check({name, ".grant"},  32'(grant),        32'(g));
    check({name, ".digits"}, 32'(ssd_digits),   32'(d));
    check({name, ".enable"}, 32'(ssd_enable),   32'(e));
    check({name, ".pulse"},  32'(switch_pulse), 32'(p));
    check({name, ".busy"},   32'(busy),         32'(g != 0));
  endtask

  localparam logic [63:0] D0 = 64'h4444_5678_1234_0000;
  localparam logic [63:0] D1 = 64'h4444_5678_BEEF_0000;
  localparam logic [15:0] E0 = 16'h0AF0;

  vec_t tbl [10];

  initial begin
    logic [3:0] exp_g;
    int owner_k;
    rst = 1'b1; req = '0; req_digits = '0; req_en = '0;

    // reset held with no requests
    for (int i = 0; i < 10; i++) apply(1'b1, 4'b0000, '0, '0);
    check_outs("reset10", 4'b0000, 16'h0000, 4'h0, 1'b0);

    // grant, owner drop with frozen digits, return to idle, regrant
    tbl[0] = '{1'b1, 4'b0000, D0, E0, 4'b0000, 16'h0000, 4'h0, 1'b0};
    tbl[1] = '{1'b1, 4'b1111, D0, E0, 4'b0000, 16'h0000, 4'h0, 1'b0};
    tbl[2] = '{1'b0, 4'b0110, D0, E0, 4'b0010, 16'h1234, 4'hF, 1'b1};
    tbl[3] = '{1'b0, 4'b0000, D1, E0, 4'b0010, 16'h1234, 4'hF, 1'b0};
    tbl[4] = '{1'b0, 4'b0000, D1, E0, 4'b0010, 16'h1234, 4'hF, 1'b0};
    tbl[5] = '{1'b0, 4'b0000, D1, E0, 4'b0010, 16'h1234, 4'hF, 1'b0};
    tbl[6] = '{1'b0, 4'b0000, D1, E0, 4'b0010, 16'h1234, 4'hF, 1'b0};
    tbl[7] = '{1'b0, 4'b0000, D1, E0, 4'b0000, 16'h1234, 4'h0, 1'b0};
    tbl[8] = '{1'b0, 4'b0000, D1, E0, 4'b0000, 16'h1234, 4'h0, 1'b0};
    tbl[9] = '{1'b0, 4'b0100, D1, E0, 4'b0100, 16'h5678, 4'hA, 1'b1};
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].r, tbl[i].q, tbl[i].d, tbl[i].e);
      check_outs($sformatf("vec%0d", i), tbl[i].g, tbl[i].xd, tbl[i].xe, tbl[i].p);
    end

    // two steady requesters alternate every MIN_HOLD+1 cycles
    apply(1'b1, 4'b0000, D0, E0);
    for (int k = 0; k < 3 * (M + 1); k++) begin
      apply(1'b0, 4'b0110, D0, E0);
      owner_k = ((k / (M + 1)) % 2 == 0) ? 1 : 2;
      exp_g = 4'(1 << owner_k);
      check($sformatf("alt%0d.grant", k), 32'(grant), 32'(exp_g));
      check($sformatf("alt%0d.pulse", k), 32'(switch_pulse), 32'((k % (M + 1)) == 0));
      check($sformatf("alt%0d.digits", k), 32'(ssd_digits), (owner_k == 1) ? 32'h1234 : 32'h5678);
    end

    // requester 0 rises while requester 2 is dwelling
    apply(1'b1, 4'b0000, D0, E0);
    apply(1'b0, 4'b0100, D0, E0);
    check_outs("own2", 4'b0100, 16'h5678, 4'hA, 1'b1);
`ifdef SSD_ARB_PREEMPT_EN
    apply(1'b0, 4'b0101, D0, E0);
    check_outs("preempt", 4'b0001, 16'h0000, 4'h0, 1'b1);
    apply(1'b0, 4'b0101, D0, E0);
    check_outs("preempt_hold", 4'b0001, 16'h0000, 4'h0, 1'b0);
`else
    for (int k = 1; k <= M; k++) begin
      apply(1'b0, 4'b0101, D0, E0);
      check($sformatf("nopre%0d.grant", k), 32'(grant), 32'(4'b0100));
      check($sformatf("nopre%0d.pulse", k), 32'(switch_pulse), 32'(1'b0));
    end
    apply(1'b0, 4'b0101, D0, E0);
    check_outs("nopre_switch", 4'b0001, 16'h0000, 4'h0, 1'b1);
`endif

    // reset in the middle of a dwell, then requester 0 comes first
    apply(1'b1, 4'b0000, D0, E0);
    apply(1'b0, 4'b1000, D0, E0);
    check_outs("own3", 4'b1000, 16'h4444, 4'h0, 1'b1);
    apply(1'b1, 4'b1000, D0, E0);
    check_outs("midrst", 4'b0000, 16'h0000, 4'h0, 1'b0);
    apply(1'b0, 4'b1001, D0, E0);
    check_outs("after_rst", 4'b0001, 16'h0000, 4'h0, 1'b1);

    // randomized traffic against the model
    apply(1'b1, 4'b0000, D0, E0);
    for (int k = 0; k < 1500; k++) begin
      logic        r;
      logic [3:0]  q;
      logic [63:0] d;
      logic [15:0] e;
      r = ($urandom_range(0, 99) == 0);
      q = ($urandom_range(0, 9) < 3) ? 4'($urandom) : req;
      d = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : req_digits;
      e = ($urandom_range(0, 3) == 0) ? 16'($urandom) : req_en;
      apply(r, q, d, e);
      exp_g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      check_outs($sformatf("rnd%0d", k), exp_g, m_dig, m_en, m_pulse);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
